// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths, reset PC and fetch-queue entry type for the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int                   DATAWIDTH = 32;
    localparam int                   ADDRWIDTH = 32;
    localparam logic [ADDRWIDTH-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [DATAWIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ADDRWIDTH-1:0] pc;
        logic [DATAWIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Register-based synchronous FIFO, power-of-two depth, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w:0]   r_count;

    // Storage is cleared on reset so the head reads as zero until first written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            r_count <= r_count + (c_ptr_w+1)'(push) - (c_ptr_w+1)'(pop);
        end
    end

    assign rdata = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == (c_ptr_w+1)'(DEPTH));
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage: owns the PC, issues credited imem reads, queues
//               fetched instructions for decode and flushes on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter int                   DATAWIDTH = riscv_pkg::DATAWIDTH,
    parameter int                   ADDRWIDTH = riscv_pkg::ADDRWIDTH,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter int                   QDEPTH    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 ImemReqValid_o,
    input  logic                 ImemReqReady_i,
    output logic [ADDRWIDTH-1:0] ImemAddr_o,
    input  logic                 ImemRspValid_i,
    input  logic [DATAWIDTH-1:0] ImemRdata_i,
    input  logic                 Redirect_i,
    input  logic [ADDRWIDTH-1:0] RedirectPC_i,
    output logic                 InstrValid_o,
    input  logic                 InstrReady_i,
    output logic [DATAWIDTH-1:0] Instr_o,
    output logic [ADDRWIDTH-1:0] InstrPC_o
);

    import riscv_pkg::*;

    localparam int                   c_cw       = $clog2(QDEPTH) + 1;
    localparam logic [c_cw+1:0]      c_qdepth   = (c_cw+2)'(QDEPTH);
    localparam logic [ADDRWIDTH-1:0] c_reset_pc = {RESET_PC[ADDRWIDTH-1:2], 2'b00};

    logic [ADDRWIDTH-1:0] r_pc;
    logic [c_cw-1:0]      r_drop;

    logic [c_cw-1:0]      w_outstanding;
    logic [c_cw-1:0]      w_occupancy;
    logic [c_cw-1:0]      w_unanswered;
    logic [c_cw+1:0]      w_inflight;
    logic                 w_req_fire;
    logic                 w_rsp_keep;
    logic                 w_pop;
    logic                 w_pend_empty;
    logic                 w_pend_full;
    logic                 w_q_empty;
    logic                 w_q_full;
    logic [ADDRWIDTH-1:0] w_pend_pc;
    fetch_entry_t         w_q_wdata;
    fetch_entry_t         w_q_head;
    logic                 w_unused_redirect_lsb;

    // Credit counts every fetch that may still land in the queue, plus doomed ones.
    assign w_inflight     = {2'b00, w_outstanding} + {2'b00, w_occupancy} + {2'b00, r_drop};
    assign ImemReqValid_o = rst_ni & (w_inflight < c_qdepth);
    assign ImemAddr_o     = r_pc;

    assign w_req_fire   = ImemReqValid_o & ImemReqReady_i;
    assign w_rsp_keep   = ImemRspValid_i & (r_drop == '0) & ~Redirect_i;
    assign w_pop        = ~w_q_empty & InstrReady_i;
    assign w_unanswered = w_outstanding + c_cw'(w_req_fire) - c_cw'(ImemRspValid_i);
    assign w_q_wdata    = '{pc: w_pend_pc, instr: ImemRdata_i};

    assign w_unused_redirect_lsb = ^RedirectPC_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc   <= c_reset_pc;
            r_drop <= '0;
        end else if (Redirect_i) begin
            r_pc   <= {RedirectPC_i[ADDRWIDTH-1:2], 2'b00};
            r_drop <= w_unanswered;
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + ADDRWIDTH'(4);
            end
            if (ImemRspValid_i && (r_drop != '0)) begin
                r_drop <= r_drop - c_cw'(1);
            end
        end
    end

    // PCs of issued requests; discarded responses still pop their entry.
    sync_fifo #(
        .WIDTH (ADDRWIDTH),
        .DEPTH (QDEPTH)
    ) u_pend_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (w_req_fire),
        .pop    (ImemRspValid_i),
        .flush  (1'b0),
        .wdata  (r_pc),
        .rdata  (w_pend_pc),
        .empty  (w_pend_empty),
        .full   (w_pend_full),
        .count  (w_outstanding)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_instr_q (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (w_rsp_keep),
        .pop    (w_pop),
        .flush  (Redirect_i),
        .wdata  (w_q_wdata),
        .rdata  (w_q_head),
        .empty  (w_q_empty),
        .full   (w_q_full),
        .count  (w_occupancy)
    );

    assign InstrValid_o = ~w_q_empty;
    assign Instr_o      = w_q_head.instr;
    assign InstrPC_o    = w_q_head.pc;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(ImemRspValid_i && w_pend_empty));
            assert (!(w_req_fire && w_pend_full));
            assert (!(w_rsp_keep && w_q_full && !w_pop));
        end
    end

endmodule

`default_nettype wire
